// File: rtl/v_sb_pkg.sv
// Shared types and the register-group mask helper for the vector hazard scoreboard.
package v_sb_pkg;

    localparam int SB_VREG_NUM = 32;

    typedef logic [1:0] lmul_t;
    typedef logic [4:0] vreg_idx_t;

    typedef struct packed {
        logic                   valid;
        logic [SB_VREG_NUM-1:0] mask;
    } sb_rec_t;

    // Registers base..base+2^lmul-1, wrapping modulo the register file size.
    function automatic logic [SB_VREG_NUM-1:0] grp_mask(input vreg_idx_t base, input lmul_t lmul);
        logic [SB_VREG_NUM-1:0] m;
        m = '0;
        for (int k = 0; k < 8; k++) begin
            if (k < (1 << lmul)) begin
                m[vreg_idx_t'(base + vreg_idx_t'(k))] = 1'b1;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/v_sb_record.sv
// One in-flight write record for a single write-port group.
// SB_DONE_BYPASS_EN: a retiring record stops blocking in the same cycle as its done pulse.
module v_sb_record
    import v_sb_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   load,
    input  logic                   done,
    input  logic [SB_VREG_NUM-1:0] load_mask,
    input  logic [SB_VREG_NUM-1:0] cand_mask,
    input  logic                   issue_vld,
    output logic                   eff_valid,
    output logic                   overlap,
    output sb_rec_t                rec_next
);

    sb_rec_t rec_reg;

    // Flush beats a load, and a load beats a retire on the same record.
    always_comb begin
        rec_next = rec_reg;
        if (flush) begin
            rec_next.valid = 1'b0;
        end else if (load) begin
            rec_next.valid = 1'b1;
            rec_next.mask  = load_mask;
        end else if (done) begin
            rec_next.valid = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rec_reg <= '0;
        end else begin
            rec_reg <= rec_next;
        end
    end

`ifdef SB_DONE_BYPASS_EN
    assign eff_valid = rec_reg.valid && !done;
`else
    assign eff_valid = rec_reg.valid;
`endif

    assign overlap = issue_vld && eff_valid && (|(rec_reg.mask & cand_mask));

endmodule

// File: rtl/v_hazard_scoreboard.sv
// RAW/WAW hazard scoreboard: one pending-write record per write-port group, gating vector issue.
// SB_DONE_BYPASS_EN: same-cycle retire and accept on one port is allowed (accept reloads the record).
module v_hazard_scoreboard
    import v_sb_pkg::*;
#(
    parameter int W_PORTS_NUM = 4,
    parameter int VREG_NUM    = SB_VREG_NUM,
    parameter int CNT_W       = 32,
    localparam int PORT_W     = (W_PORTS_NUM > 1) ? $clog2(W_PORTS_NUM) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   issue_vld_i,
    output logic                   issue_rdy_o,
    input  logic [PORT_W-1:0]      issue_port_i,
    input  logic [4:0]             issue_vd_i,
    input  logic [4:0]             issue_vs1_i,
    input  logic [4:0]             issue_vs2_i,
    input  logic                   issue_we_i,
    input  logic [1:0]             issue_re_i,
    input  logic [1:0]             issue_lmul_i,
    input  logic [W_PORTS_NUM-1:0] port_done_i,
    input  logic                   flush_i,
    output logic [W_PORTS_NUM-1:0] dependancy_issue_o,
    output logic [VREG_NUM-1:0]    busy_vregs_o,
    output logic [CNT_W-1:0]       stall_cnt_o
);

    logic [SB_VREG_NUM-1:0] vd_mask;
    logic [SB_VREG_NUM-1:0] cand_mask;
    logic [W_PORTS_NUM-1:0] eff_valid;
    logic [W_PORTS_NUM-1:0] load;
    logic                   accept;
    sb_rec_t                rec_next [W_PORTS_NUM];
    logic [VREG_NUM-1:0]    busy_reg;
    logic [VREG_NUM-1:0]    busy_next;
    logic [CNT_W-1:0]       stall_reg;
    logic [CNT_W-1:0]       stall_next;

    always_comb begin
        vd_mask   = grp_mask(vreg_idx_t'(issue_vd_i), lmul_t'(issue_lmul_i));
        cand_mask = '0;
        if (issue_we_i)    cand_mask = cand_mask | vd_mask;
        if (issue_re_i[0]) cand_mask = cand_mask | grp_mask(vreg_idx_t'(issue_vs1_i), lmul_t'(issue_lmul_i));
        if (issue_re_i[1]) cand_mask = cand_mask | grp_mask(vreg_idx_t'(issue_vs2_i), lmul_t'(issue_lmul_i));
    end

    assign issue_rdy_o = !rst && issue_vld_i && (dependancy_issue_o == '0)
                         && !eff_valid[issue_port_i] && !flush_i;
    assign accept      = issue_vld_i && issue_rdy_o;

    generate
        for (genvar gi = 0; gi < W_PORTS_NUM; gi++) begin : g_rec
            assign load[gi] = accept && issue_we_i && (issue_port_i == PORT_W'(gi));

            v_sb_record u_rec (
                .clk       (clk),
                .rst       (rst),
                .flush     (flush_i),
                .load      (load[gi]),
                .done      (port_done_i[gi]),
                .load_mask (vd_mask),
                .cand_mask (cand_mask),
                .issue_vld (issue_vld_i),
                .eff_valid (eff_valid[gi]),
                .overlap   (dependancy_issue_o[gi]),
                .rec_next  (rec_next[gi])
            );
        end
    endgenerate

    // Built from next-state so the registered union matches the records with no extra lag.
    always_comb begin
        busy_next = '0;
        for (int p = 0; p < W_PORTS_NUM; p++) begin
            if (rec_next[p].valid) busy_next = busy_next | VREG_NUM'(rec_next[p].mask);
        end
    end

    always_comb begin
        stall_next = stall_reg;
        if (issue_vld_i && !issue_rdy_o && (stall_reg != '1)) stall_next = stall_reg + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_reg  <= '0;
            stall_reg <= '0;
        end else begin
            busy_reg  <= busy_next;
            stall_reg <= stall_next;
        end
    end

    assign busy_vregs_o = busy_reg;
    assign stall_cnt_o  = stall_reg;

endmodule

// File: tb/tb_v_hazard_scoreboard.sv
// Directed plus random bench for v_hazard_scoreboard against a register-set reference model.
module tb_v_hazard_scoreboard;

`ifdef SB_DONE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        issue_vld_i;
    logic        issue_rdy_o;
    logic [1:0]  issue_port_i;
    logic [4:0]  issue_vd_i, issue_vs1_i, issue_vs2_i;
    logic        issue_we_i;
    logic [1:0]  issue_re_i;
    logic [1:0]  issue_lmul_i;
    logic [3:0]  port_done_i;
    logic        flush_i;
    logic [3:0]  dependancy_issue_o;
    logic [31:0] busy_vregs_o;
    logic [31:0] stall_cnt_o;

    int checks = 0;
    int errors = 0;

    bit          m_valid [4];
    bit [31:0]   m_mask  [4];
    int unsigned m_stall;
    bit [3:0]    last_dep;
    bit          last_rdy;

    always #5 clk = ~clk;

    v_hazard_scoreboard dut (
        .clk               (clk),
        .rst               (rst),
        .issue_vld_i       (issue_vld_i),
        .issue_rdy_o       (issue_rdy_o),
        .issue_port_i      (issue_port_i),
        .issue_vd_i        (issue_vd_i),
        .issue_vs1_i       (issue_vs1_i),
        .issue_vs2_i       (issue_vs2_i),
        .issue_we_i        (issue_we_i),
        .issue_re_i        (issue_re_i),
        .issue_lmul_i      (issue_lmul_i),
        .port_done_i       (port_done_i),
        .flush_i           (flush_i),
        .dependancy_issue_o(dependancy_issue_o),
        .busy_vregs_o      (busy_vregs_o),
        .stall_cnt_o       (stall_cnt_o)
    );

    function automatic bit [31:0] gm(input int base, input int lmul);
        bit [31:0] m = '0;
        for (int k = 0; k < (1 << lmul); k++) m[(base + k) % 32] = 1'b1;
        return m;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: drive at posedge+1, check combinational outputs, then registered outputs after the edge.
    task automatic cyc(input bit r, input bit vld, input int port, input int vd, input int vs1,
                       input int vs2, input bit we, input bit [1:0] re, input int lmul,
                       input bit [3:0] done, input bit fl);
        bit [31:0] cand;
        bit [3:0]  ev;
        bit [3:0]  dep;
        bit        rdy;
        bit [31:0] busy;
        rst = r; issue_vld_i = vld; issue_port_i = 2'(port);
        issue_vd_i = 5'(vd); issue_vs1_i = 5'(vs1); issue_vs2_i = 5'(vs2);
        issue_we_i = we; issue_re_i = re; issue_lmul_i = 2'(lmul);
        port_done_i = done; flush_i = fl;
        #1;
        cand = (we ? gm(vd, lmul) : 32'd0) | (re[0] ? gm(vs1, lmul) : 32'd0)
             | (re[1] ? gm(vs2, lmul) : 32'd0);
        for (int p = 0; p < 4; p++) begin
            ev[p]  = m_valid[p] && !(BYP && done[p]);
            dep[p] = vld && ev[p] && ((m_mask[p] & cand) != 0);
        end
        rdy = !r && vld && (dep == 0) && !ev[port] && !fl;
        chk("dep", 32'(dependancy_issue_o), 32'(dep));
        chk("rdy", 32'(issue_rdy_o), 32'(rdy));
        last_dep = dependancy_issue_o;
        last_rdy = issue_rdy_o;
        @(posedge clk);
        if (r) begin
            for (int p = 0; p < 4; p++) m_valid[p] = 0;
            m_stall = 0;
        end else begin
            if (vld && !rdy && m_stall != 32'hFFFF_FFFF) m_stall++;
            if (fl) begin
                for (int p = 0; p < 4; p++) m_valid[p] = 0;
            end else begin
                for (int p = 0; p < 4; p++) if (done[p]) m_valid[p] = 0;
                if (rdy && we) begin
                    m_valid[port] = 1;
                    m_mask[port]  = gm(vd, lmul);
                end
            end
        end
        #1;
        busy = '0;
        for (int p = 0; p < 4; p++) if (m_valid[p]) busy |= m_mask[p];
        chk("busy", busy_vregs_o, busy);
        chk("stall", stall_cnt_o, m_stall);
    endtask

    initial begin
        int unsigned s0;
        rst = 1'b1; issue_vld_i = 1'b1; issue_port_i = '0; issue_vd_i = '0;
        issue_vs1_i = '0; issue_vs2_i = '0; issue_we_i = 1'b0; issue_re_i = '0;
        issue_lmul_i = '0; port_done_i = '0; flush_i = 1'b0;
        for (int p = 0; p < 4; p++) begin m_valid[p] = 0; m_mask[p] = '0; end
        m_stall = 0;
        repeat (2) @(posedge clk);
        #1;

        // Reset holds rdy low even with a valid candidate
        cyc(1, 1, 0, 0, 0, 0, 0, 2'b00, 0, 4'b0, 0);
        chk("rst_rdy", 32'(last_rdy), 32'd0);
        cyc(0, 1, 0, 0, 0, 0, 0, 2'b00, 0, 4'b0, 0);
        chk("post_rst_rdy", 32'(last_rdy), 32'd1);
        chk("post_rst_busy", busy_vregs_o, 32'd0);

        // RAW on port0 record, then retire
        cyc(0, 1, 0, 4, 0, 0, 1, 2'b00, 1, 4'b0, 0);
        cyc(0, 1, 1, 0, 5, 0, 0, 2'b01, 0, 4'b0, 0);
        chk("raw_dep", 32'(last_dep), 32'h1);
        chk("raw_rdy", 32'(last_rdy), 32'd0);
        cyc(0, 1, 1, 0, 5, 0, 0, 2'b01, 0, 4'b0001, 0);
        cyc(0, 1, 1, 0, 5, 0, 0, 2'b01, 0, 4'b0, 0);
        chk("retired_rdy", 32'(last_rdy), 32'd1);

        // Wrap-around group
        cyc(0, 1, 0, 30, 0, 0, 1, 2'b00, 2, 4'b0, 0);
        chk("wrap_busy", busy_vregs_o, 32'hC000_0003);
        cyc(0, 1, 1, 0, 0, 1, 0, 2'b10, 0, 4'b0, 0);
        chk("wrap_dep", 32'(last_dep), 32'h1);

        // Accept on port1 while port2 retires; reuse of a valid port is blocked
        cyc(0, 1, 2, 10, 0, 0, 1, 2'b00, 0, 4'b0, 0);
        cyc(0, 1, 1, 12, 0, 0, 1, 2'b00, 0, 4'b0100, 0);
        chk("p1_load_busy", busy_vregs_o, 32'hC000_1003);
        cyc(0, 1, 2, 14, 0, 0, 1, 2'b00, 0, 4'b0, 0);
        cyc(0, 1, 2, 20, 0, 0, 1, 2'b00, 0, 4'b0, 0);
        chk("busy_port_rdy", 32'(last_rdy), 32'd0);

        // Flush with three live records
        cyc(0, 1, 3, 20, 0, 0, 1, 2'b00, 0, 4'b0, 1);
        chk("flush_rdy", 32'(last_rdy), 32'd0);
        chk("flush_busy", busy_vregs_o, 32'd0);
        cyc(0, 1, 0, 0, 30, 0, 0, 2'b01, 2, 4'b0, 0);
        chk("flush_dep", 32'(last_dep), 32'd0);

        // Hold a hazard for five cycles
        cyc(0, 1, 0, 8, 0, 0, 1, 2'b00, 0, 4'b0, 0);
        s0 = stall_cnt_o;
        repeat (5) cyc(0, 1, 1, 0, 8, 0, 0, 2'b01, 0, 4'b0, 0);
        chk("stall_delta", stall_cnt_o - s0, 32'd5);

        // Same-cycle retire and accept on port0
        cyc(0, 1, 0, 16, 0, 0, 1, 2'b00, 0, 4'b0001, 0);
        chk("same_port_rdy", 32'(last_rdy), BYP ? 32'd1 : 32'd0);
        cyc(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 4'b1111, 0);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            cyc(($urandom_range(99) == 0), ($urandom_range(7) != 0), $urandom_range(3),
                $urandom_range(31), $urandom_range(31), $urandom_range(31),
                ($urandom_range(3) != 0), 2'($urandom_range(3)), $urandom_range(3),
                {($urandom_range(5) == 0), ($urandom_range(5) == 0),
                 ($urandom_range(5) == 0), ($urandom_range(5) == 0)},
                ($urandom_range(19) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
